// File: rtl/xpt_if.sv
// xpt_if: decoder <-> execution-phase timer signal bundle.
//   master : op decoder side; drives pr_reset_xpt, pc_r1, mem_wait, clear_fault
//            and observes the timer outputs.
//   slave  : xpt_sequencer side; the mirror image.
//   pr_reset_xpt  end-of-instruction from a decoder, XPT returns to 0
//   pc_r1         decoder is in the memory read-data phase
//   mem_wait      memory not ready, only meaningful while pc_r1 is high
//   clear_fault   clears the sticky fault flags
//   xpt/not_xpt   current phase and its complement, both registered
//   stalled       combinational, high while the current cycle is a wait state
//   instr_start   registered, high in the cycle where xpt == 0
//   overrun       sticky, timer reached its terminal value with no reset
//   bus_timeout   sticky, a wait state was force-ended
interface xpt_if #(
  parameter int XPT_W = 5
);
  logic             pr_reset_xpt;
  logic             pc_r1;
  logic             mem_wait;
  logic             clear_fault;
  logic [XPT_W-1:0] xpt;
  logic [XPT_W-1:0] not_xpt;
  logic             stalled;
  logic             instr_start;
  logic             overrun;
  logic             bus_timeout;

  modport master (
    output pr_reset_xpt, pc_r1, mem_wait, clear_fault,
    input  xpt, not_xpt, stalled, instr_start, overrun, bus_timeout
  );

  modport slave (
    input  pr_reset_xpt, pc_r1, mem_wait, clear_fault,
    output xpt, not_xpt, stalled, instr_start, overrun, bus_timeout
  );
endinterface

// File: rtl/xpt_sequencer.sv
// xpt_sequencer: execution-phase timer shared by all op decoders.
// Advances xpt one step per clock, returns it to 0 on pr_reset_xpt, inserts
// memory wait states during the read-data phase and flags sticky faults.
//   clk    core clock, all state changes on the rising edge
//   reset  synchronous, active-high
//   bus    xpt_if slave modport (decoder handshake and timer outputs)
module xpt_sequencer #(
  parameter int XPT_W    = 5,
  parameter int XPT_MAX  = 31,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic  clk,
  input  logic  reset,
  xpt_if.slave  bus
);

  localparam logic [XPT_W-1:0]  XPT_TOP  = XPT_W'(XPT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(WAIT_MAX);

  logic [XPT_W-1:0]  xpt_q;
  logic [XPT_W-1:0]  not_xpt_q;
  logic [WAIT_W-1:0] wcnt_q;
  logic              instr_start_q;
  logic              overrun_q;
  logic              bus_timeout_q;

  logic              wait_req;
  logic              stall;
  logic              timeout;
  logic              at_top;
  logic [XPT_W-1:0]  xpt_nxt;
  logic [WAIT_W-1:0] wcnt_nxt;
  logic              set_ovr;
  logic              set_bto;

  always_comb begin
    wait_req = bus.pc_r1 & bus.mem_wait;
    stall    = wait_req & (wcnt_q != WAIT_TOP);
    timeout  = wait_req & (wcnt_q == WAIT_TOP);
    at_top   = (xpt_q == XPT_TOP);
    xpt_nxt  = xpt_q;
    wcnt_nxt = '0;
    set_ovr  = 1'b0;
    set_bto  = 1'b0;
    if (bus.pr_reset_xpt) begin
      xpt_nxt = '0;
    end else if (stall) begin
      wcnt_nxt = wcnt_q + 1'b1;
    end else if (timeout) begin
      set_bto = 1'b1;
      // A forced wait end at the terminal phase must not wrap the timer.
      if (at_top) set_ovr = 1'b1;
      else        xpt_nxt = xpt_q + 1'b1;
    end else if (at_top) begin
      set_ovr = 1'b1;
    end else begin
      xpt_nxt = xpt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xpt_q         <= '0;
      not_xpt_q     <= '1;
      wcnt_q        <= '0;
      instr_start_q <= 1'b1;
      overrun_q     <= 1'b0;
      bus_timeout_q <= 1'b0;
    end else begin
      xpt_q         <= xpt_nxt;
      not_xpt_q     <= ~xpt_nxt;
      wcnt_q        <= wcnt_nxt;
      instr_start_q <= (xpt_nxt == '0);
      // A set event in the same cycle outranks clear_fault.
      overrun_q     <= set_ovr | (overrun_q & ~bus.clear_fault);
      bus_timeout_q <= set_bto | (bus_timeout_q & ~bus.clear_fault);
    end
  end

  assign bus.xpt         = xpt_q;
  assign bus.not_xpt     = not_xpt_q;
  assign bus.stalled     = stall;
  assign bus.instr_start = instr_start_q;
  assign bus.overrun     = overrun_q;
  assign bus.bus_timeout = bus_timeout_q;

endmodule

// File: tb/tb_xpt_sequencer.sv
module tb_xpt_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  xpt_if #(.XPT_W(5)) bus ();

  xpt_sequencer #(
    .XPT_W(5), .XPT_MAX(31), .WAIT_MAX(15), .WAIT_W(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_x(input logic [4:0] exp);
    logic [4:0] exp_n;
    exp_n = ~exp;
    step();
    chk("xpt", 32'(bus.xpt), 32'(exp));
    chk("not_xpt", 32'(bus.not_xpt), 32'(exp_n));
    chk("instr_start", 32'(bus.instr_start), 32'(exp == 5'd0));
  endtask

  initial begin
    int nst;
    reset            = 1'b1;
    bus.pr_reset_xpt = 1'b0;
    bus.pc_r1        = 1'b0;
    bus.mem_wait     = 1'b0;
    bus.clear_fault  = 1'b0;

    // T1: reset values, then free-run
    step();
    step();
    chk("rst_xpt", 32'(bus.xpt), 32'd0);
    chk("rst_not_xpt", 32'(bus.not_xpt), 32'h1F);
    chk("rst_instr_start", 32'(bus.instr_start), 32'd1);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_bus_timeout", 32'(bus.bus_timeout), 32'd0);
    reset = 1'b0;
    step_x(5'd1);
    step_x(5'd2);
    step_x(5'd3);

    // T2: run to 9, end instruction
    for (int k = 4; k <= 9; k++) step_x(5'(k));
    bus.pr_reset_xpt = 1'b1;
    step_x(5'd0);
    bus.pr_reset_xpt = 1'b0;
    step_x(5'd1);
    step_x(5'd2);

    // T3: short wait at xpt=5
    step_x(5'd3);
    step_x(5'd4);
    step_x(5'd5);
    bus.pc_r1    = 1'b1;
    bus.mem_wait = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_stalled", 32'(bus.stalled), 32'd1);
      step_x(5'd5);
    end
    bus.pc_r1    = 1'b0;
    bus.mem_wait = 1'b0;
    #1;
    chk("t3_stall_end", 32'(bus.stalled), 32'd0);
    step_x(5'd6);
    chk("t3_bus_timeout", 32'(bus.bus_timeout), 32'd0);

    // T4: wait forced to end after 15 stall cycles
    bus.pr_reset_xpt = 1'b1;
    step_x(5'd0);
    bus.pr_reset_xpt = 1'b0;
    for (int k = 1; k <= 5; k++) step_x(5'(k));
    bus.pc_r1    = 1'b1;
    bus.mem_wait = 1'b1;
    nst = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (bus.stalled) nst++;
      step();
    end
    chk("t4_stall_cycles", 32'(nst), 32'd15);
    chk("t4_xpt", 32'(bus.xpt), 32'd6);
    chk("t4_bus_timeout", 32'(bus.bus_timeout), 32'd1);
    for (int k = 0; k < 4; k++) step_x(5'd6);
    chk("t4_bto_sticky", 32'(bus.bus_timeout), 32'd1);
    bus.pc_r1       = 1'b0;
    bus.mem_wait    = 1'b0;
    bus.clear_fault = 1'b1;
    step_x(5'd7);
    chk("t4_bto_clear", 32'(bus.bus_timeout), 32'd0);
    bus.clear_fault = 1'b0;

    // T5: saturate at 31, overrun sticky
    bus.pr_reset_xpt = 1'b1;
    step_x(5'd0);
    bus.pr_reset_xpt = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step_x((k < 31) ? 5'(k) : 5'd31);
      if (k == 31) chk("t5_ovr_at31", 32'(bus.overrun), 32'd0);
      if (k == 32) chk("t5_ovr_set", 32'(bus.overrun), 32'd1);
    end
    bus.pr_reset_xpt = 1'b1;
    step_x(5'd0);
    bus.pr_reset_xpt = 1'b0;
    chk("t5_ovr_sticky", 32'(bus.overrun), 32'd1);

    // T6: end of instruction during a stall, then reset mid-wait
    bus.pc_r1    = 1'b1;
    bus.mem_wait = 1'b1;
    step_x(5'd0);
    step_x(5'd0);
    bus.pr_reset_xpt = 1'b1;
    #1;
    chk("t6_stalled", 32'(bus.stalled), 32'd1);
    step_x(5'd0);
    bus.pr_reset_xpt = 1'b0;
    for (int k = 0; k < 7; k++) step_x(5'd0);
    reset = 1'b1;
    step();
    chk("t6_rst_xpt", 32'(bus.xpt), 32'd0);
    chk("t6_rst_not_xpt", 32'(bus.not_xpt), 32'h1F);
    chk("t6_rst_instr_start", 32'(bus.instr_start), 32'd1);
    chk("t6_rst_overrun", 32'(bus.overrun), 32'd0);
    chk("t6_rst_bus_timeout", 32'(bus.bus_timeout), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      #1;
      chk("t6_wait_full", 32'(bus.stalled), 32'd1);
      step_x(5'd0);
    end
    #1;
    chk("t6_wait_expired", 32'(bus.stalled), 32'd0);
    step_x(5'd1);
    chk("t6_bus_timeout", 32'(bus.bus_timeout), 32'd1);

    // set event outranks clear_fault on the same edge
    bus.clear_fault = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step_x(5'd1);
      if (k == 0) chk("prio_cleared", 32'(bus.bus_timeout), 32'd0);
    end
    step_x(5'd2);
    chk("prio_set_wins", 32'(bus.bus_timeout), 32'd1);
    bus.clear_fault = 1'b0;
    bus.pc_r1       = 1'b0;
    bus.mem_wait    = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
